// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or decoder/mux) and one slave.
// hready is the muxed bus-level ready, so it is driven from the master side.
interface ahb_lite_slave_mem_if #(
  parameter int ADDR_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite responder backed by a small word memory, with configurable wait
// states before OKAY completions and a two-cycle ERROR response.
module ahb_lite_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input logic              hclk,
  input logic              hreset,
  ahb_lite_slave_mem_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);
  localparam logic [3:0]        CNT_INIT   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit                NO_WAIT    = (WAIT_STATES == 0);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        lane_q;
  logic              wr_q;
  logic [31:0]       mem [DEPTH];
  logic              open_slot;
  logic              sample;
  logic              sample_err;
  logic              unused_htrans;

  function automatic logic xfer_error(input logic [ADDR_W-1:0] addr,
                                      input logic [2:0]        size);
    logic err;
    err = (size > 3'd2) || (addr >= ADDR_LIMIT);
    if (size == 3'd1 && addr[0])
      err = 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00)
      err = 1'b1;
    return err;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo,
                                           input logic [2:0] size);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << addr_lo;
      3'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  assign unused_htrans = bus.htrans[0];

  // A new address phase can only be taken while this slave is showing ready.
  assign open_slot  = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
  assign sample     = open_slot && bus.hsel && bus.hready && bus.htrans[1];
  assign sample_err = xfer_error(bus.haddr, bus.hsize);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_LAST;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (sample) begin
      if (sample_err)
        state_d = S_ERR1;
      else if (NO_WAIT)
        state_d = S_LAST;
      else
        state_d = S_WAIT;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      cnt_q <= 4'd0;
    else if (sample)
      cnt_q <= CNT_INIT;
    else if (state_q == S_WAIT && cnt_q != 4'd0)
      cnt_q <= cnt_q - 4'd1;
  end

  // Address-phase capture; the lane mask is resolved here so the data phase
  // only has to apply it.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_q <= 1'b0;
    end else if (sample) begin
      wr_q <= bus.hwrite;
    end
  end

  always_ff @(posedge hclk) begin
    if (sample) begin
      idx_q  <= bus.haddr[IDX_W+1:2];
      lane_q <= lane_mask(bus.haddr[1:0], bus.hsize);
    end
  end

  // Writes commit at the closing edge of LAST; errored writes never get here.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'h0;
    end else if (state_q == S_LAST && wr_q) begin
      for (int b = 0; b < 4; b++)
        if (lane_q[b])
          mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  assign bus.hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign bus.hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);

  always_comb begin
    bus.hrdata = 32'h0;
    if (state_q == S_LAST && !wr_q)
      bus.hrdata = mem[idx_q];
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: one instance with one wait state, one with none,
// driven by a pipelined transfer driver and checked against a byte-level model.
module tb_ahb_lite_slave_mem;

  localparam int DEPTH = 16;
  localparam int MEMB  = DEPTH * 4;

  typedef struct {
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] data;
    bit        use_exp;
    bit [31:0] exp;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        dsel;
  logic        stall;
  logic        t_hsel;
  logic [31:0] t_haddr;
  logic [1:0]  t_htrans;
  logic        t_hwrite;
  logic [2:0]  t_hsize;
  logic [31:0] t_hwdata;
  logic        obs_rdy;
  logic        obs_resp;
  logic [31:0] obs_rdata;

  int        checks = 0;
  int        errors = 0;
  int        ws [2] = '{1, 0};
  bit [7:0]  mb [2][MEMB];
  xfer_t     q [$];

  always #5 hclk = ~hclk;

  ahb_lite_slave_mem_if #(.ADDR_W(32)) if0 ();
  ahb_lite_slave_mem_if #(.ADDR_W(32)) if1 ();

  assign if0.hsel   = !dsel && t_hsel;
  assign if0.htrans = dsel ? 2'b00 : t_htrans;
  assign if0.haddr  = t_haddr;
  assign if0.hwrite = t_hwrite;
  assign if0.hsize  = t_hsize;
  assign if0.hwdata = t_hwdata;
  assign if0.hready = if0.hreadyout && !stall;

  assign if1.hsel   = dsel && t_hsel;
  assign if1.htrans = dsel ? t_htrans : 2'b00;
  assign if1.haddr  = t_haddr;
  assign if1.hwrite = t_hwrite;
  assign if1.hsize  = t_hsize;
  assign if1.hwdata = t_hwdata;
  assign if1.hready = if1.hreadyout && !stall;

  assign obs_rdy   = dsel ? if1.hreadyout : if0.hreadyout;
  assign obs_resp  = dsel ? if1.hresp     : if0.hresp;
  assign obs_rdata = dsel ? if1.hrdata    : if0.hrdata;

  ahb_lite_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(1), .ADDR_W(32)) dut_ws1 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (if0)
  );

  ahb_lite_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) dut_ws0 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (if1)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s (dut %0d): observed %h expected %h", tag, dsel, observed, expected);
    end
  endtask

  // Transfer-level rules from the bus protocol, expressed on byte addresses.
  function automatic bit is_err(input xfer_t x);
    if (x.size > 3'd2) return 1'b1;
    if ((x.addr % (32'd1 << x.size)) != 0) return 1'b1;
    return x.addr >= MEMB;
  endfunction

  function automatic bit [31:0] model_word(input bit [31:0] addr);
    int base;
    base = int'(addr) & ~3;
    return {mb[dsel][base+3], mb[dsel][base+2], mb[dsel][base+1], mb[dsel][base]};
  endfunction

  task automatic model_commit(input xfer_t x);
    int a;
    if (!x.wr || is_err(x)) return;
    for (int b = 0; b < (1 << x.size); b++) begin
      a = int'(x.addr) + b;
      mb[dsel][a] = 8'(x.data >> (8 * (a % 4)));
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < MEMB; i++)
        mb[d][i] = 8'h0;
  endtask

  task automatic add(input bit wr, input bit [31:0] addr, input bit [2:0] size,
                     input bit [31:0] data, input bit use_exp = 1'b0, input bit [31:0] exp = 32'h0);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.data = data;
    x.use_exp = use_exp; x.exp = exp;
    q.push_back(x);
  endtask

  task automatic put_addr(input int i);
    if (i < q.size()) begin
      t_hsel   = 1'b1;
      t_htrans = (i > 0 && $urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      t_haddr  = q[i].addr;
      t_hwrite = q[i].wr;
      t_hsize  = q[i].size;
    end else begin
      t_hsel   = 1'($urandom_range(0, 1));
      t_htrans = 2'b00;
      t_haddr  = $urandom;
      t_hwrite = 1'($urandom_range(0, 1));
      t_hsize  = 3'd2;
    end
  endtask

  // Runs the queued transfers back to back with address/data pipelining and
  // checks every data-phase cycle against the expected response shape.
  task automatic run_q();
    int ap = 0;
    int dp = -1;
    int k = 0;
    int lat;
    int guard = 0;
    bit err;
    bit rdy;
    logic [31:0] exp_rd;
    put_addr(ap);
    while ((ap < q.size() || dp >= 0) && guard < 200) begin
      @(negedge hclk);
      guard++;
      rdy = obs_rdy;
      if (dp >= 0) begin
        k++;
        err = is_err(q[dp]);
        lat = err ? 2 : ws[dsel] + 1;
        exp_rd = 32'h0;
        if (k == lat && !err && !q[dp].wr)
          exp_rd = q[dp].use_exp ? q[dp].exp : model_word(q[dp].addr);
        chk("hreadyout", 32'(rdy), 32'(k == lat));
        chk("hresp", 32'(obs_resp), 32'(err));
        chk("hrdata", obs_rdata, exp_rd);
        if (rdy) model_commit(q[dp]);
      end else begin
        chk("idle_hreadyout", 32'(rdy), 32'd1);
        chk("idle_hresp", 32'(obs_resp), 32'd0);
      end
      @(posedge hclk);
      #1;
      if (rdy) begin
        if (ap < q.size()) begin
          dp = ap;
          ap++;
        end else begin
          dp = -1;
        end
        k = 0;
        put_addr(ap);
        t_hwdata = (dp >= 0) ? q[dp].data : $urandom;
      end
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $error("FAIL run_timeout: observed %0d cycles expected completion within 200", guard);
    end
    q.delete();
  endtask

  task automatic random_batch();
    int n;
    bit [31:0] a;
    bit [2:0]  s;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = $urandom_range(0, MEMB + 15);
      if ($urandom_range(0, 3) != 0 && s <= 3'd2)
        a = a & ~((32'd1 << s) - 1);
      add(1'($urandom_range(0, 1)), a, s, $urandom);
    end
    run_q();
  endtask

  initial begin
    hreset   = 1'b1;
    dsel     = 1'b0;
    stall    = 1'b0;
    t_hsel   = 1'b0;
    t_haddr  = 32'h0;
    t_htrans = 2'b00;
    t_hwrite = 1'b0;
    t_hsize  = 3'd2;
    t_hwdata = 32'h0;
    model_clear();

    // Reset values, then an idle bus.
    repeat (2) @(negedge hclk);
    chk("rst_hreadyout", 32'(obs_rdy), 32'd1);
    chk("rst_hresp", 32'(obs_resp), 32'd0);
    chk("rst_hrdata", obs_rdata, 32'h0);
    hreset = 1'b0;
    @(posedge hclk);
    #1;
    add(1'b0, 32'h0, 3'd2, 32'h0, 1'b1, 32'h0);
    run_q();

    // BUSY with hsel=1 must be a zero-wait OKAY with no memory effect.
    t_hsel = 1'b1; t_htrans = 2'b01; t_haddr = 32'h4; t_hwrite = 1'b1; t_hsize = 3'd2;
    @(posedge hclk);
    #1;
    t_hwdata = 32'hFFFF_FFFF;
    t_htrans = 2'b00;
    chk("busy_hreadyout", 32'(obs_rdy), 32'd1);
    chk("busy_hresp", 32'(obs_resp), 32'd0);

    // Word write and read-back with one wait state.
    add(1'b1, 32'h4, 3'd2, 32'hDEAD_BEEF);
    add(1'b0, 32'h4, 3'd2, 32'h0, 1'b1, 32'hDEAD_BEEF);
    run_q();

    // Byte and halfword lanes merge into the existing word.
    add(1'b1, 32'h5, 3'd0, 32'h0000_AA00);
    add(1'b1, 32'h6, 3'd1, 32'h1234_0000);
    add(1'b0, 32'h4, 3'd2, 32'h0, 1'b1, 32'h1234_AAEF);
    run_q();

    // Out-of-range read and misaligned write both error; memory untouched.
    add(1'b0, 32'h40, 3'd2, 32'h0);
    add(1'b1, 32'h2, 3'd2, 32'hCAFE_F00D);
    add(1'b0, 32'h0, 3'd2, 32'h0, 1'b1, 32'h0);
    add(1'b0, 32'h4, 3'd2, 32'h0, 1'b1, 32'h1234_AAEF);
    add(1'b0, 32'h4, 3'd3, 32'h0);
    add(1'b1, 32'h5, 3'd1, 32'hFFFF_FFFF);
    add(1'b0, 32'h4, 3'd2, 32'h0, 1'b1, 32'h1234_AAEF);
    run_q();

    // hready low from another slave: no sample, no write.
    stall = 1'b1;
    t_hsel = 1'b1; t_htrans = 2'b10; t_haddr = 32'h10; t_hwrite = 1'b1; t_hsize = 3'd2;
    @(posedge hclk);
    #1;
    t_hwdata = 32'hFFFF_FFFF;
    t_htrans = 2'b00;
    stall = 1'b0;
    chk("stall_hreadyout", 32'(obs_rdy), 32'd1);
    @(posedge hclk);
    #1;
    chk("stall_after_hreadyout", 32'(obs_rdy), 32'd1);
    add(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'h0);
    run_q();

    // Zero-wait instance: pipelined write then read.
    dsel = 1'b1;
    add(1'b1, 32'h8, 3'd2, 32'h1111_1111);
    add(1'b0, 32'h8, 3'd2, 32'h0, 1'b1, 32'h1111_1111);
    run_q();

    // Reset in the middle of a waited write drops it.
    dsel = 1'b0;
    t_hsel = 1'b1; t_htrans = 2'b10; t_haddr = 32'hC; t_hwrite = 1'b1; t_hsize = 3'd2;
    @(posedge hclk);
    #1;
    t_hwdata = 32'h0000_0055;
    t_htrans = 2'b00;
    t_hsel   = 1'b0;
    chk("wait_hreadyout", 32'(obs_rdy), 32'd0);
    hreset = 1'b1;
    #1;
    chk("async_rst_hreadyout", 32'(obs_rdy), 32'd1);
    chk("async_rst_hresp", 32'(obs_resp), 32'd0);
    chk("async_rst_hrdata", obs_rdata, 32'h0);
    model_clear();
    @(negedge hclk);
    hreset = 1'b0;
    @(posedge hclk);
    #1;
    add(1'b0, 32'hC, 3'd2, 32'h0, 1'b1, 32'h0);
    add(1'b0, 32'h4, 3'd2, 32'h0, 1'b1, 32'h0);
    run_q();

    // Randomized traffic on both instances.
    for (int r = 0; r < 40; r++) begin
      dsel = 1'(r % 2);
      random_batch();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t expected finish earlier", $time);
    $fatal(1, "bench timeout");
  end

endmodule
